// File: rtl/zreg_access.sv
// Register-access sequencer: turns READ/WRITE/MOVE/SWAP commands into single-port
// register-file read/write cycles and returns one response per command.
//
// state | meaning
// IDLE  | ready for a command
// RDA   | read rd into temp A
// RDB   | read rs into temp B
// WRA   | write rd (immediate data or temp B)
// WRB   | write rs with temp A (second half of SWAP)
// RESP  | response held until consumer takes it
module zreg_access (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [1:0] cmd_rd,
   input  logic [1:0] cmd_rs,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       rf_opcode,
   output logic [1:0] rf_sel,
   output logic [7:0] rf_wdata,
   input  logic [7:0] rf_rdata
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RDA  = 3'd1,
      RDB  = 3'd2,
      WRA  = 3'd3,
      WRB  = 3'd4,
      RESP = 3'd5
   } state_t;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_MOVE  = 2'b10;
   localparam logic [1:0] OP_SWAP  = 2'b11;

   state_t     state_q, state_d;
   logic [1:0] op_q, op_d;
   logic [1:0] rd_q, rd_d;
   logic [1:0] rs_q, rs_d;
   logic [7:0] data_q, data_d;
   logic [7:0] temp_a_q, temp_a_d;
   logic [7:0] temp_b_q, temp_b_d;
   logic       cmd_ready_q, cmd_ready_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic [7:0] rsp_data_q, rsp_data_d;
   logic       rf_opcode_q, rf_opcode_d;
   logic [1:0] rf_sel_q, rf_sel_d;
   logic [7:0] rf_wdata_q, rf_wdata_d;

   // Outputs for a state are computed on the edge that enters it, so every
   // register-file control is a flop output during its access cycle.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      rd_d        = rd_q;
      rs_d        = rs_q;
      data_d      = data_q;
      temp_a_d    = temp_a_q;
      temp_b_d    = temp_b_q;
      cmd_ready_d = cmd_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rf_opcode_d = 1'b0;
      rf_sel_d    = rf_sel_q;
      rf_wdata_d  = rf_wdata_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               op_d        = cmd_op;
               rd_d        = cmd_rd;
               rs_d        = cmd_rs;
               data_d      = cmd_data;
               cmd_ready_d = 1'b0;
               case (cmd_op)
                  OP_WRITE: begin
                     state_d     = WRA;
                     rf_opcode_d = 1'b1;
                     rf_sel_d    = cmd_rd;
                     rf_wdata_d  = cmd_data;
                  end
                  OP_MOVE: begin
                     state_d  = RDB;
                     rf_sel_d = cmd_rs;
                  end
                  default: begin
                     state_d  = RDA;
                     rf_sel_d = cmd_rd;
                  end
               endcase
            end
         end
         RDA: begin
            temp_a_d = rf_rdata;
            if (op_q == OP_READ) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_data_d  = rf_rdata;
            end else begin
               state_d  = RDB;
               rf_sel_d = rs_q;
            end
         end
         RDB: begin
            temp_b_d    = rf_rdata;
            state_d     = WRA;
            rf_opcode_d = 1'b1;
            rf_sel_d    = rd_q;
            rf_wdata_d  = rf_rdata;
         end
         WRA: begin
            if (op_q == OP_SWAP) begin
               state_d     = WRB;
               rf_opcode_d = 1'b1;
               rf_sel_d    = rs_q;
               rf_wdata_d  = temp_a_q;
            end else begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_data_d  = (op_q == OP_WRITE) ? data_q : temp_b_q;
            end
         end
         WRB: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = temp_a_q;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
            cmd_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= OP_READ;
         rd_q        <= 2'd0;
         rs_q        <= 2'd0;
         data_q      <= 8'd0;
         temp_a_q    <= 8'd0;
         temp_b_q    <= 8'd0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'd0;
         rf_opcode_q <= 1'b0;
         rf_sel_q    <= 2'd0;
         rf_wdata_q  <= 8'd0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         rd_q        <= rd_d;
         rs_q        <= rs_d;
         data_q      <= data_d;
         temp_a_q    <= temp_a_d;
         temp_b_q    <= temp_b_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rf_opcode_q <= rf_opcode_d;
         rf_sel_q    <= rf_sel_d;
         rf_wdata_q  <= rf_wdata_d;
      end
   end

   // Write strobe is gated by reset directly so an in-flight write dies immediately.
   assign rf_opcode = rf_opcode_q & rst_n;
   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rf_sel    = rf_sel_q;
   assign rf_wdata  = rf_wdata_q;

endmodule

// File: doc/zreg_access.md
ZREG_ACCESS -- requirements
Module: zreg_access

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 8 bits and the register select at 2 bits (4 registers).
REQ-002 The block SHALL have one clock and a synchronous, active-low reset, declared as the first two ports below.
REQ-003 CLK  in  1  sole clock; all state SHALL update on the rising edge.
REQ-004 RST_N  in  1  synchronous active-low reset, sampled on the rising edge of CLK.
REQ-005 CMD_VALID  in  1  a command is offered.
REQ-006 CMD_READY  out  1  the block can accept a command.
REQ-007 CMD_OP  in  2  command: 00 READ rd, 01 WRITE rd<=CMD_DATA, 10 MOVE rd<=rs, 11 SWAP rd<->rs.
REQ-008 CMD_RD  in  2  destination/primary register index.
REQ-009 CMD_RS  in  2  source/secondary register index.
REQ-010 CMD_DATA  in  8  immediate data for WRITE.
REQ-011 RSP_VALID  out  1  a response is available.
REQ-012 RSP_READY  in  1  the consumer takes the response.
REQ-013 RSP_DATA  out  8  response data.
REQ-014 RF_OPCODE  out  1  register-file port mode: 0 read, 1 write.
REQ-015 RF_SEL  out  2  register-file index.
REQ-016 RF_WDATA  out  8  register-file write data.
REQ-017 RF_RDATA  in  8  register-file read data, combinationally valid in the same cycle as RF_SEL while RF_OPCODE=0.

Function
REQ-018 The state machine SHALL have the states IDLE, RDA, RDB, WRA, WRB and RESP; each state other than IDLE and RESP SHALL last exactly one cycle.
REQ-019 CMD_READY SHALL be 1 only in IDLE.
REQ-020 A command SHALL be accepted on an edge where CMD_VALID=1 and CMD_READY=1; CMD_OP, CMD_RD, CMD_RS and CMD_DATA SHALL be latched only on that edge.
REQ-021 Sequences from the accept edge SHALL be: READ IDLE->RDA->RESP; WRITE IDLE->WRA->RESP; MOVE IDLE->RDB->WRA->RESP; SWAP IDLE->RDA->RDB->WRA->WRB->RESP.
REQ-022 In RDA: RF_OPCODE=0, RF_SEL=rd, and RF_RDATA SHALL be captured into temp A at the end of the cycle.
REQ-023 In RDB: RF_OPCODE=0, RF_SEL=rs, and RF_RDATA SHALL be captured into temp B at the end of the cycle.
REQ-024 In WRA: RF_OPCODE=1 and RF_SEL=rd; RF_WDATA SHALL be the latched CMD_DATA for WRITE and temp B for MOVE or SWAP.
REQ-025 In WRB: RF_OPCODE=1, RF_SEL=rs and RF_WDATA=temp A.
REQ-026 RF_OPCODE SHALL be 1 only in WRA or WRB, and for exactly one cycle per write.
REQ-027 Outside the read and write states, RF_OPCODE SHALL be 0 and RF_SEL/RF_WDATA SHALL hold their last values.
REQ-028 The number of register-file access cycles per command SHALL be: READ 1, WRITE 1, MOVE 2, SWAP 4.
REQ-029 RSP_VALID SHALL assert in the cycle immediately after the last access cycle.
REQ-030 RSP_DATA SHALL be: READ temp A; WRITE the latched CMD_DATA; MOVE temp B; SWAP temp A (the old value of rd).
REQ-031 RSP_DATA SHALL be stable while RSP_VALID=1.
REQ-032 RESP SHALL hold RSP_VALID=1 until an edge with RSP_READY=1, then go to IDLE; CMD_READY SHALL be 1 in the following cycle.
REQ-033 There SHALL be no bypass from RESP to a new command, so the minimum command period is (access cycles + 2) cycles.
REQ-034 CMD_VALID SHALL be ignored while CMD_READY=0; a held CMD_VALID SHALL be accepted once the block returns to IDLE.
REQ-035 A SWAP with rd==rs SHALL still execute all four access cycles and leave the register value unchanged.
REQ-036 A MOVE with rd==rs SHALL rewrite the same value.
REQ-037 All CMD_OP encodings are legal; there SHALL be no error state.

Reset
REQ-038 On an edge with RST_N=0, the state SHALL become IDLE and the outputs SHALL take these values: CMD_READY=1 (from the next cycle), RSP_VALID=0, RSP_DATA=0, RF_SEL=0, RF_WDATA=0, temps A and B =0.
REQ-039 RF_OPCODE SHALL be forced to 0 combinationally whenever RST_N=0, so no write occurs during reset.
REQ-040 A reset mid-command SHALL abandon the command: no further writes and no response.

Verification
REQ-041 Preload R2=0x5A; READ rd=2 -> one read cycle with RF_SEL=2, then RSP_VALID=1 and RSP_DATA=0x5A.
REQ-042 WRITE rd=1, data 0xC3 -> exactly one cycle with RF_OPCODE=1, RF_SEL=1 and RF_WDATA=0xC3; RSP_DATA=0xC3; a subsequent READ rd=1 returns 0xC3.
REQ-043 R0=0x11, R3=0x22; SWAP rd=0, rs=3 -> access order read 0, read 3, write 0<=0x22, write 3<=0x11; RSP_DATA=0x11; RSP_VALID in the fifth cycle after acceptance.
REQ-044 MOVE rd=2 <= rs=1 with RSP_READY held 0 for 5 cycles -> RSP_VALID and RSP_DATA stay stable, CMD_READY stays 0, and a pending CMD_VALID is accepted one cycle after the response handshake.
REQ-045 RST_N driven low during the WRA cycle of a SWAP -> RF_OPCODE=0 in that cycle, no WRB write, RSP_VALID=0, and CMD_READY=1 after reset.
REQ-046 SWAP rd=rs=1 with R1=0x7E -> four access cycles, R1 remains 0x7E, RSP_DATA=0x7E.
